t_toggle_decoder: RTL and testbench
===================================

# t_toggle_decoder

Receiving end of a toggle-signalled event line. The T flip-flop transmitter side flips its output once per event; this block samples that line and converts each level change back into a one-cycle event pulse. It keeps a wrap-around event count and a sticky overflow flag, and reports the new line level. It sits in the receive domain of the lab designs, downstream of any T flip-flop whose Q carries events.

## Interface
Parameters:
- WIDTH, default 4: event counter width in bits (WIDTH ≥ 1).

Ports:
- Clk, input, 1: clock; all state changes on the rising edge.
- Rst, input, 1: reset; asynchronous, active-low.
- Tin, input, 1: toggle-coded event line. Each level change is one event. It may be asynchronous to Clk.
- En, input, 1: count enable; gates counting only.
- Clr, input, 1: synchronous clear of Count and Ovf.
- Ev, output, 1: registered one-cycle pulse per detected event.
- Lvl, output, 1: registered synchronized level of Tin, as delayed through the pipeline.
- Count, output, WIDTH: number of events counted, modulo 2^WIDTH.
- Ovf, output, 1: sticky; set when Count wraps.

## Operation
- Input pipeline: s1 <= Tin, s2 <= s1, s3 <= s2.
  - s1/s2 form a 2-flop synchronizer.
  - s3 holds the previous synchronized level.
- Detection: chg = s2 ^ s3 (combinational, internal).
- Registered outputs at each edge:
  - Ev <= chg.
  - Lvl <= s2.
- Count and Ovf are updated at the same edge, evaluated in this priority order:
  1. Clr=1: Count <= 0, Ovf <= 0. Clr wins over a simultaneous chg. Ev still pulses for that event. The event is not counted.
  2. chg=1 and En=1: Count <= Count+1, modulo 2^WIDTH. If Count was all-ones, Count <= 0 and Ovf <= 1.
  3. Otherwise Count and Ovf hold.
- En=0: events are still detected and Ev/Lvl still update, but Count and Ovf hold.
- Ovf stays at 1 until Clr or reset. Further wraps keep it at 1.
- No FSM beyond the pipeline. The state is {s1, s2, s3, Ev, Lvl, Count, Ovf}.

## Timing
- Reset (Rst=0, asynchronous, any time including mid-event):
  - s1=s2=s3=0, Ev=0, Lvl=0, Count=0, Ovf=0.
  - Any in-flight event is discarded.
- Reset reference level is 0, matching a transmitter T flip-flop that resets Q=0. If Tin=1 at reset release, exactly one event is reported.
- Latency: a Tin change sampled at edge k sets s1. After edge k+1, s2 differs from s3. At edge k+2:
  - Ev=1, Lvl shows the new level, and Count increments (if enabled).
  - Ev returns to 0 at edge k+3 unless another change follows.
- Throughput: one event per clock maximum.
  - If Tin toggles at every edge, Ev stays high continuously and Count increments every cycle.
  - Two changes between consecutive sampling edges are invisible: net zero change, no event. The transmitter must hold each level for at least one full Clk period.
- Metastability is confined to s1. Outputs never depend on s1 directly.

## Test plan
- Reset/idle: Rst low with Tin=0, then release and hold Tin=0 for 10 cycles -> Ev=0, Lvl=0, Count=0, Ovf=0 throughout.
- Latency: after reset, Tin 0->1 just before edge k -> Ev=1 only in the cycle after edge k+2, Lvl=1 from edge k+2, Count=1. Then Tin 1->0 -> Ev pulses again, Lvl=0, Count=2.
- Wrap/overflow (WIDTH=4): 16 toggles spaced 3 cycles apart -> Count reaches 15 then 0 on the 16th, Ovf=1. A 17th toggle -> Count=1, Ovf stays 1. Clr -> Count=0, Ovf=0.
- Back-to-back and enable: Tin toggles every cycle for 5 cycles with En=1 -> Ev high for 5 consecutive cycles, Count=5. Repeat with En=0 -> Ev pulses identically, Count stays 5.
- Simultaneous Clr/event: with Count=7, assert Clr in the cycle where chg=1 -> Ev=1, Count=0, Ovf=0. The next toggle gives Count=1.
- Reset mid-operation: Tin toggles, then Rst asserted between edges k and k+2 -> all outputs go to 0 immediately and no Ev appears after release. If Tin=1 at release -> exactly one Ev and Count=1.

Source files
------------

// File: rtl/t_toggle_decoder.sv
// Receive side of a toggle-coded event line: synchronizes Tin, turns each level
// change into a one-cycle Ev pulse, and keeps a wrapping event count with sticky overflow.
module t_toggle_decoder #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Tin,
    input  logic             En,
    input  logic             Clr,
    output logic             Ev,
    output logic             Lvl,
    output logic [WIDTH-1:0] Count,
    output logic             Ovf
);

    logic             s1_q, s2_q, s3_q;
    logic             ev_q, lvl_q;
    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             chg;

    // Only s2/s3 feed logic; s1 may be metastable and is never observed directly.
    assign chg = s2_q ^ s3_q;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (Clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (chg && En) begin
            count_d = count_q + WIDTH'(1);
            if (count_q == '1) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            ev_q    <= 1'b0;
            lvl_q   <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            s1_q    <= Tin;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            ev_q    <= chg;
            lvl_q   <= s2_q;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign Ev    = ev_q;
    assign Lvl   = lvl_q;
    assign Count = count_q;
    assign Ovf   = ovf_q;

endmodule

// File: tb/tb_t_toggle_decoder.sv
// Bench for t_toggle_decoder: directed scenarios plus random traffic, checked against
// a model built from the sampled Tin history (event = level two edges back differs from three back).
module tb_t_toggle_decoder;

    localparam int unsigned WIDTH = 4;

    logic             Clk = 1'b0;
    logic             Rst = 1'b0;
    logic             Tin = 1'b0;
    logic             En  = 1'b1;
    logic             Clr = 1'b0;
    logic             Ev;
    logic             Lvl;
    logic [WIDTH-1:0] Count;
    logic             Ovf;

    int errors = 0;
    int checks = 0;

    bit hist[$];
    int m_cnt = 0;
    bit m_ovf = 1'b0;
    bit m_ev  = 1'b0;
    bit m_lvl = 1'b0;
    logic tin_cur = 1'b0;

    t_toggle_decoder #(.WIDTH(WIDTH)) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .Tin  (Tin),
        .En   (En),
        .Clr  (Clr),
        .Ev   (Ev),
        .Lvl  (Lvl),
        .Count(Count),
        .Ovf  (Ovf)
    );

    always #5 Clk = ~Clk;

    function automatic bit past(input int k);
        int idx;
        idx = hist.size() - 1 - k;
        if (idx < 0) return 1'b0;
        return hist[idx];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        check("ev",    32'(Ev),    32'(m_ev));
        check("lvl",   32'(Lvl),   32'(m_lvl));
        check("count", 32'(Count), 32'(m_cnt));
        check("ovf",   32'(Ovf),   32'(m_ovf));
    endtask

    // One clock: drive at negedge, advance the model at posedge, compare 1 ns later.
    task automatic step(input logic tin, input logic en, input logic clr);
        @(negedge Clk);
        Tin = tin; En = en; Clr = clr;
        tin_cur = tin;
        @(posedge Clk);
        hist.push_back(tin);
        if (hist.size() > 8) void'(hist.pop_front());
        m_ev  = past(2) != past(3);
        m_lvl = past(2);
        if (clr) begin
            m_cnt = 0;
            m_ovf = 1'b0;
        end else if (m_ev && en) begin
            if (m_cnt == (1 << WIDTH) - 1) m_ovf = 1'b1;
            m_cnt = (m_cnt + 1) % (1 << WIDTH);
        end
        #1 check_all();
    endtask

    task automatic toggle_step(input logic en);
        step(~tin_cur, en, 1'b0);
    endtask

    // Assert reset mid-cycle, check immediately, release just after a rising edge.
    task automatic do_reset(input logic tin_at_release);
        @(negedge Clk);
        #2 Rst = 1'b0;
        Tin = tin_at_release;
        tin_cur = tin_at_release;
        hist.delete();
        m_cnt = 0; m_ovf = 1'b0; m_ev = 1'b0; m_lvl = 1'b0;
        #1 check_all();
        @(posedge Clk);
        #1 check_all();
        #1 Rst = 1'b1;
    endtask

    initial begin
        // Power-on reset
        #3 check_all();
        @(posedge Clk);
        #2 Rst = 1'b1;

        // Idle: 10 cycles with Tin=0
        repeat (10) step(1'b0, 1'b1, 1'b0);

        // Latency: rise, hold, then fall, hold
        step(1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b1, 1'b1, 1'b0);
        check("lat_count1", 32'(Count), 32'd1);
        step(1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b0);
        check("lat_count2", 32'(Count), 32'd2);

        // Wrap/overflow: clear, 16 toggles 3 cycles apart, then a 17th, then Clr
        step(tin_cur, 1'b1, 1'b1);
        repeat (16) begin
            toggle_step(1'b1);
            repeat (2) step(tin_cur, 1'b1, 1'b0);
        end
        repeat (2) step(tin_cur, 1'b1, 1'b0);
        check("wrap_count0", 32'(Count), 32'd0);
        check("wrap_ovf",    32'(Ovf),   32'd1);
        toggle_step(1'b1);
        repeat (3) step(tin_cur, 1'b1, 1'b0);
        check("wrap17_count", 32'(Count), 32'd1);
        check("wrap17_ovf",   32'(Ovf),   32'd1);
        step(tin_cur, 1'b1, 1'b1);
        check("clr_ovf", 32'(Ovf), 32'd0);

        // Back-to-back toggles with En=1 then En=0
        repeat (5) toggle_step(1'b1);
        repeat (4) step(tin_cur, 1'b1, 1'b0);
        check("b2b_count", 32'(Count), 32'd5);
        repeat (5) toggle_step(1'b0);
        repeat (4) step(tin_cur, 1'b0, 1'b0);
        check("b2b_noen_count", 32'(Count), 32'd5);

        // Simultaneous Clr and event with Count=7
        step(tin_cur, 1'b1, 1'b1);
        repeat (7) begin
            toggle_step(1'b1);
            repeat (2) step(tin_cur, 1'b1, 1'b0);
        end
        repeat (2) step(tin_cur, 1'b1, 1'b0);
        check("pre_clr_count", 32'(Count), 32'd7);
        toggle_step(1'b1);
        step(tin_cur, 1'b1, 1'b0);
        step(tin_cur, 1'b1, 1'b1);
        check("clr_ev", 32'(Ev), 32'd1);
        check("clr_count", 32'(Count), 32'd0);
        repeat (2) step(tin_cur, 1'b1, 1'b0);
        toggle_step(1'b1);
        repeat (3) step(tin_cur, 1'b1, 1'b0);
        check("post_clr_count", 32'(Count), 32'd1);

        // Reset mid-event, Tin back to 0 at release: no event afterwards
        toggle_step(1'b1);
        step(tin_cur, 1'b1, 1'b0);
        do_reset(1'b0);
        repeat (6) step(1'b0, 1'b1, 1'b0);
        // Reset with Tin=1 at release: exactly one event
        step(1'b1, 1'b1, 1'b0);
        do_reset(1'b1);
        repeat (6) step(1'b1, 1'b1, 1'b0);
        check("rst_one_ev_count", 32'(Count), 32'd1);

        // Random traffic
        repeat (600) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                step(($urandom_range(0, 2) == 0) ? ~tin_cur : tin_cur,
                     1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 39) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
